mem_stream_reader: RTL and testbench

MEM_STREAM_READER -- requirements
Module: mem_stream_reader

---
 rtl/mem_stream_reader_pkg.sv | 13 +
 rtl/mem_stream_reader_stream_fifo.sv | 65 ++++++
 rtl/mem_stream_reader.sv | 130 +++++++++++++
 tb/tb_mem_stream_reader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stream_reader_pkg.sv
// Shared constants for the streaming memory reader: FSM state encoding and
// the depth of the read-data FIFO that decouples memory latency from the sink.
package mem_stream_reader_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mem_stream_reader_stream_fifo.sv
// Small register FIFO holding read data plus its last flag. The head entry is
// presented combinationally so the stream side sees data in the same cycle
// the entry becomes valid. Pushes on a full FIFO and pops on an empty FIFO
// are ignored.
module stream_fifo
    import mem_stream_reader_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  empty,
    output logic [FIFO_CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0]      mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [FIFO_CNT_W-1:0] count_reg;
    logic                  push_ok;
    logic                  pop_ok;

    assign push_ok  = push && (count_reg != FIFO_CNT_W'(FIFO_DEPTH));
    assign pop_ok   = pop && (count_reg != '0);
    assign pop_data = mem_reg[rd_ptr_reg];
    assign empty    = (count_reg == '0);
    assign count    = count_reg;

    // Storage entries: each slot loads when the write pointer selects it.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                mem_reg[gi] <= push_data;
            end
        end
    end

    // Pointer and occupancy bookkeeping; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + FIFO_CNT_W'(1);
                2'b01:   count_reg <= count_reg - FIFO_CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mem_stream_reader.sv
// Reads `length` consecutive words (address wrapping modulo memory size) from a
// one-cycle-latency synchronous memory and streams them out on a valid/ready
// interface. Reads are throttled so that FIFO occupancy plus reads still in
// the memory pipeline never exceeds the FIFO depth, so no read data is lost.
// The throttle uses only registered state, so m_ready never reaches read_en
// combinationally.
module mem_stream_reader
    import mem_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  read_en,
    output logic [ADDR_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    logic [STATE_W-1:0]    state_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [LEN_WIDTH-1:0]  len_reg;
    logic [LEN_WIDTH-1:0]  issued_reg;
    logic [LEN_WIDTH-1:0]  beat_reg;
    logic                  rd_reg;        // read strobe presented to memory this cycle
    logic                  rd_last_reg;   // that read carries the final word
    logic                  cap_reg;       // memory data valid this cycle, push into FIFO
    logic                  cap_last_reg;

    logic                  fifo_empty;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [DATA_WIDTH:0]   fifo_head;
    logic [FIFO_CNT_W-1:0] fill_level;
    logic                  issue_ok;
    logic                  fire;

    // Every word either in the FIFO or still travelling through memory counts.
    assign fill_level = fifo_count + FIFO_CNT_W'(rd_reg) + FIFO_CNT_W'(cap_reg);
    assign issue_ok   = (state_reg == ST_RUN) && (issued_reg < len_reg)
                        && (fill_level < FIFO_CNT_W'(FIFO_DEPTH));
    assign fire       = m_valid && m_ready;

    assign busy         = (state_reg == ST_RUN);
    assign done         = (state_reg == ST_DONE);
    assign read_en      = rd_reg;
    assign read_address = addr_reg;
    assign m_valid      = !fifo_empty;
    assign m_data       = m_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
    assign m_last       = m_valid && fifo_head[DATA_WIDTH];

    // Control FSM, read issue and memory-latency tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            len_reg      <= '0;
            issued_reg   <= '0;
            beat_reg     <= '0;
            rd_reg       <= 1'b0;
            rd_last_reg  <= 1'b0;
            cap_reg      <= 1'b0;
            cap_last_reg <= 1'b0;
        end else begin
            cap_reg      <= rd_reg;
            cap_last_reg <= rd_last_reg;
            rd_reg       <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            state_reg   <= ST_RUN;
                            len_reg     <= length;
                            addr_reg    <= base_addr;
                            rd_reg      <= 1'b1;
                            rd_last_reg <= (length == LEN_WIDTH'(1));
                            issued_reg  <= LEN_WIDTH'(1);
                            beat_reg    <= '0;
                        end else begin
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue_ok) begin
                        rd_reg      <= 1'b1;
                        addr_reg    <= addr_reg + ADDR_WIDTH'(1);
                        rd_last_reg <= (issued_reg == len_reg - LEN_WIDTH'(1));
                        issued_reg  <= issued_reg + LEN_WIDTH'(1);
                    end
                    if (fire) begin
                        beat_reg <= beat_reg + LEN_WIDTH'(1);
                        if (beat_reg == len_reg - LEN_WIDTH'(1)) begin
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    stream_fifo #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (cap_reg),
        .push_data({cap_last_reg, data_out}),
        .pop      (fire),
        .pop_data (fifo_head),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: a 64-word memory model, directed transfers,
// and a scoreboard of expected addresses and beats checked by a monitor.
module tb_mem_stream_reader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] base_addr;
    logic [6:0] length;
    logic       busy;
    logic       done;
    logic       read_en;
    logic [5:0] read_address;
    logic [7:0] data_out;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;

    mem_stream_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .read_en     (read_en),
        .read_address(read_address),
        .data_out    (data_out),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last)
    );

    logic [7:0] mem1 [64];
    logic [8:0] exp_q [$];
    logic [5:0] exp_addr_q [$];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   reads = 0;
    int   pops = 0;
    int   done_cnt = 0;
    int   start_cyc = 0;
    int   first_valid_cyc = 0;
    int   last_fire_cyc = 0;
    bit   seen_valid = 0;
    bit   toggle_mode = 0;
    bit   hold_valid = 0;
    logic [8:0] hold_beat = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem1[i] = (i < 32) ? 8'(8'h11 + i) : 8'h00;
        end
    end

    // Synchronous memory, data valid one cycle after read_en.
    always @(posedge clk) begin
        if (read_en) data_out <= mem1[read_address];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Sink ready pattern: held high or toggled every cycle.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = toggle_mode ? ~m_ready : 1'b1;
        end
    end

    // Monitor: compares reads and beats against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_valid = 0;
            end else begin
                if (done) done_cnt++;
                if (read_en) begin
                    reads++;
                    if (exp_addr_q.size() == 0) begin
                        check("read_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                    end else begin
                        check("read_addr", 32'(read_address), 32'(exp_addr_q.pop_front()));
                    end
                    check("inflight_le4", 32'((reads - pops) <= 4), 32'd1);
                end
                if (hold_valid) begin
                    check("valid_held", 32'(m_valid), 32'd1);
                    check("hold_stable", 32'({m_last, m_data}), 32'(hold_beat));
                end
                hold_valid = 0;
                if (m_valid) begin
                    if (!seen_valid) begin
                        seen_valid = 1;
                        first_valid_cyc = cyc;
                    end
                    if (m_ready) begin
                        if (exp_q.size() == 0) begin
                            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                        end else begin
                            check("beat", 32'({m_last, m_data}), 32'(exp_q.pop_front()));
                        end
                        pops++;
                        if (m_last) last_fire_cyc = cyc;
                    end else begin
                        hold_valid = 1;
                        hold_beat = {m_last, m_data};
                    end
                end
            end
        end
    end

    task automatic issue_start(input int base, input int len);
        for (int k = 0; k < len; k++) begin
            int a;
            a = (base + k) % 64;
            exp_addr_q.push_back(6'(a));
            exp_q.push_back({(k == len - 1), (a < 32) ? 8'(8'h11 + a) : 8'h00});
        end
        reads = 0;
        pops = 0;
        seen_valid = 0;
        start = 1'b1;
        base_addr = 6'(base);
        length = 7'(len);
        @(posedge clk);
        #1;
        start = 1'b0;
        start_cyc = cyc;
        check("busy_after_start", 32'(busy), 32'(len != 0));
        $display("start base=%0d len=%0d accepted at cycle %0d", base, len, start_cyc);
    endtask

    task automatic run_xfer(input int base, input int len, input bit toggle, input bit mid_start);
        int d0;
        bit got;
        int done_cyc;
        d0 = done_cnt;
        toggle_mode = toggle;
        issue_start(base, len);
        if (mid_start) begin
            repeat (2) @(posedge clk);
            #1;
            start = 1'b1;
            base_addr = 6'd20;
            length = 7'd5;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        got = 0;
        done_cyc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                done_cyc = cyc;
                break;
            end
        end
        check("done_seen", 32'(got), 32'd1);
        if (got) begin
            check("busy_at_done", 32'(busy), 32'd0);
            if (len == 0) begin
                check("done_latency_len0", 32'(done_cyc - start_cyc), 32'd0);
            end else begin
                check("done_after_last", 32'(done_cyc - last_fire_cyc), 32'd1);
                check("first_valid_lat", 32'(first_valid_cyc - start_cyc), 32'd2);
                if (!toggle) begin
                    check("gapless", 32'(last_fire_cyc - first_valid_cyc), 32'(len - 1));
                end
            end
        end
        repeat (3) @(negedge clk);
        toggle_mode = 0;
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("beats_left", 32'(exp_q.size()), 32'd0);
        check("reads_left", 32'(exp_addr_q.size()), 32'd0);
        if (len == 0) check("no_valid_len0", 32'(seen_valid), 32'd0);
        $display("xfer base=%0d len=%0d done at cycle %0d, checks=%0d errors=%0d",
                 base, len, done_cyc, checks, errors);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_read_en"}, 32'(read_en), 32'd0);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_m_last"}, 32'(m_last), 32'd0);
        check({tag, "_read_address"}, 32'(read_address), 32'd0);
        check({tag, "_m_data"}, 32'(m_data), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bit got;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        $display("reset state checked");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_xfer(0, 4, 0, 0);
        run_xfer(8, 6, 1, 0);
        run_xfer(62, 4, 0, 0);
        run_xfer(0, 0, 0, 0);
        run_xfer(0, 6, 0, 1);

        // Abort a len=8 transfer after two beats.
        d0 = done_cnt;
        issue_start(0, 8);
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pops >= 2) begin
                got = 1;
                break;
            end
        end
        check("two_beats_before_rst", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("abort");
        rst_n = 1'b1;
        exp_q.delete();
        exp_addr_q.delete();
        reads = 0;
        pops = 0;
        repeat (20) @(negedge clk);
        check("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
        $display("abort after %0d beats checked", 2);
        @(posedge clk);
        #1;
        run_xfer(0, 3, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
